// File: rtl/efpga_config_pkg.sv
// Shared constants and state encoding for the eFPGA configuration bridge.
package efpga_config_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic [7:0]  ACK_BYTE               = 8'h06;
   localparam logic [7:0]  NAK_BYTE               = 8'h15;
   localparam logic [31:0] SYNC_WORD_DEFAULT      = 32'hFAB0_FAB1;
   localparam logic [31:0] DESYNC_WORD_DEFAULT    = 32'hFAB0_FAB0;
   localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd12_000_000;

endpackage

// File: rtl/efpga_word_packer.sv
// MSB-first byte-to-word packer; word_o is the post-shift value so callers can
// match a pattern on the same cycle the closing byte is accepted.
module efpga_word_packer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        done_o
);

   logic [31:0] sr_q, sr_d;
   logic [1:0]  idx_q, idx_d;

   assign word_o = {sr_q[23:0], byte_i};
   assign done_o = valid_i && (idx_q == 2'd3);

   always_comb begin
      sr_d  = sr_q;
      idx_d = idx_q;
      if (clear_i) begin
         sr_d  = '0;
         idx_d = '0;
      end else if (valid_i) begin
         sr_d  = word_o;
         idx_d = idx_q + 2'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr_q  <= '0;
         idx_q <= '0;
      end else begin
         sr_q  <= sr_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/efpga_config_bridge.sv
// CDC byte stream to FABulous config-word bridge: sync hunt, word packing,
// ACK on desync and NAK on inactivity timeout.
module efpga_config_bridge
   import efpga_config_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
   parameter logic [31:0] DESYNC_WORD    = DESYNC_WORD_DEFAULT,
   parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  from_usb_data_i,
   input  logic        from_usb_valid_i,
   output logic        from_usb_ready_o,
   output logic [7:0]  to_usb_data_o,
   output logic        to_usb_valid_o,
   input  logic        to_usb_ready_i,
   output logic [31:0] config_data_o,
   output logic        config_strobe_o,
   output logic        config_active_o,
   output logic [15:0] word_count_o
);

   state_e      state_q, state_d;
   logic [23:0] tmo_q, tmo_d;
   logic [7:0]  resp_q, resp_d;
   logic [31:0] cfg_q, cfg_d;
   logic        strobe_q, strobe_d;
   logic [15:0] count_q, count_d;

   logic        byte_acc;
   logic        pack_clear;
   logic [31:0] pack_word;
   logic        pack_done;

   assign from_usb_ready_o = (state_q != ST_RESP);
   assign byte_acc         = from_usb_valid_i && from_usb_ready_o;

   efpga_word_packer u_packer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (pack_clear),
      .valid_i (byte_acc),
      .byte_i  (from_usb_data_i),
      .word_o  (pack_word),
      .done_o  (pack_done)
   );

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      resp_d     = resp_q;
      cfg_d      = cfg_q;
      strobe_d   = 1'b0;
      count_d    = count_q;
      pack_clear = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (byte_acc && (pack_word == SYNC_WORD)) begin
               state_d    = ST_ACTIVE;
               tmo_d      = '0;
               count_d    = '0;
               pack_clear = 1'b1;
            end
         end
         ST_ACTIVE: begin
            // An accepted byte always beats the timeout, even on its final cycle.
            if (byte_acc) begin
               tmo_d = '0;
               if (pack_done) begin
                  if (pack_word == DESYNC_WORD) begin
                     resp_d  = ACK_BYTE;
                     state_d = ST_RESP;
                  end else begin
                     cfg_d    = pack_word;
                     strobe_d = 1'b1;
                     count_d  = count_q + 16'd1;
                  end
               end
            end else if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
               resp_d  = NAK_BYTE;
               state_d = ST_RESP;
            end else begin
               tmo_d = tmo_q + 24'd1;
            end
         end
         ST_RESP: begin
            if (to_usb_ready_i) begin
               state_d    = ST_IDLE;
               pack_clear = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         tmo_q    <= '0;
         resp_q   <= '0;
         cfg_q    <= '0;
         strobe_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         resp_q   <= resp_d;
         cfg_q    <= cfg_d;
         strobe_q <= strobe_d;
         count_q  <= count_d;
      end
   end

   assign to_usb_data_o   = resp_q;
   assign to_usb_valid_o  = (state_q == ST_RESP);
   assign config_data_o   = cfg_q;
   assign config_strobe_o = strobe_q;
   assign config_active_o = (state_q == ST_ACTIVE);
   assign word_count_o    = count_q;

endmodule

// File: tb/tb_efpga_config_bridge.sv
// Scoreboard bench: a byte-stream reference model predicts strobes and status
// bytes; a monitor compares them as the bridge presents them.
module tb_efpga_config_bridge;

   localparam int          TMO    = 100;
   localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
   localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;
   localparam logic [7:0]  ACK    = 8'h06;
   localparam logic [7:0]  NAK    = 8'h15;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [7:0]  from_usb_data_i = '0;
   logic        from_usb_valid_i = 1'b0;
   logic        from_usb_ready_o;
   logic [7:0]  to_usb_data_o;
   logic        to_usb_valid_o;
   logic        to_usb_ready_i = 1'b0;
   logic [31:0] config_data_o;
   logic        config_strobe_o;
   logic        config_active_o;
   logic [15:0] word_count_o;

   efpga_config_bridge #(.TIMEOUT_CYCLES(24'd100)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .from_usb_data_i  (from_usb_data_i),
      .from_usb_valid_i (from_usb_valid_i),
      .from_usb_ready_o (from_usb_ready_o),
      .to_usb_data_o    (to_usb_data_o),
      .to_usb_valid_o   (to_usb_valid_o),
      .to_usb_ready_i   (to_usb_ready_i),
      .config_data_o    (config_data_o),
      .config_strobe_o  (config_strobe_o),
      .config_active_o  (config_active_o),
      .word_count_o     (word_count_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] data;
      logic [15:0] count;
   } strobe_t;

   strobe_t    exp_strobe[$];
   logic [7:0] exp_resp[$];

   // Reference model state, byte-stream level
   bit          m_session = 1'b0;
   logic [31:0] m_window  = '0;
   logic [31:0] m_word    = '0;
   int          m_nbytes  = 0;
   int          m_count   = 0;
   int          resp_delay_force = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_idle(input int gap);
      if (m_session && gap >= TMO) begin
         exp_resp.push_back(NAK);
         m_session = 1'b0;
         m_window  = '0;
      end
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      strobe_t s;
      if (!m_session) begin
         m_window = {m_window[23:0], b};
         if (m_window == SYNC) begin
            m_session = 1'b1;
            m_nbytes  = 0;
            m_word    = '0;
            m_count   = 0;
         end
      end else begin
         m_word = {m_word[23:0], b};
         m_nbytes++;
         if (m_nbytes == 4) begin
            m_nbytes = 0;
            if (m_word == DESYNC) begin
               exp_resp.push_back(ACK);
               m_session = 1'b0;
               m_window  = '0;
            end else begin
               m_count = (m_count + 1) % 65536;
               s.data  = m_word;
               s.count = 16'(m_count);
               exp_strobe.push_back(s);
            end
         end
      end
   endfunction

   function automatic void model_reset();
      m_session = 1'b0;
      m_window  = '0;
      m_nbytes  = 0;
   endfunction

   // Called at a falling edge; returns at the falling edge after the handshake.
   task automatic send(input int gap, input logic [7:0] b);
      int w;
      model_idle(gap);
      model_byte(b);
      repeat (gap) @(negedge clk_i);
      from_usb_valid_i = 1'b1;
      from_usb_data_i  = b;
      w = 0;
      while (!from_usb_ready_o && w < 1000) begin
         @(negedge clk_i);
         w++;
      end
      if (w >= 1000) check("byte_accept_wait", 32'(w), 32'd0);
      @(negedge clk_i);
      from_usb_valid_i = 1'b0;
   endtask

   task automatic send_word(input int gap, input logic [31:0] w32);
      send(gap, w32[31:24]);
      send($urandom_range(0, 2), w32[23:16]);
      send($urandom_range(0, 2), w32[15:8]);
      send($urandom_range(0, 2), w32[7:0]);
   endtask

   task automatic silence(input int g);
      model_idle(g);
      repeat (g) @(negedge clk_i);
   endtask

   task automatic wait_resp_done();
      int w = 0;
      while ((to_usb_valid_o || exp_resp.size() != 0) && w < 2000) begin
         @(negedge clk_i);
         w++;
      end
      if (w >= 2000) check("resp_drain_wait", 32'(w), 32'd0);
      @(negedge clk_i);
   endtask

   task automatic check_reset_values();
      check("rst_ready",  32'(from_usb_ready_o), 32'd1);
      check("rst_tvalid", 32'(to_usb_valid_o),   32'd0);
      check("rst_tdata",  32'(to_usb_data_o),    32'd0);
      check("rst_cdata",  config_data_o,         32'd0);
      check("rst_strobe", 32'(config_strobe_o),  32'd0);
      check("rst_active", 32'(config_active_o),  32'd0);
      check("rst_count",  32'(word_count_o),     32'd0);
   endtask

   // Host IN-path responder
   initial begin
      int d;
      forever begin
         @(negedge clk_i);
         if (to_usb_valid_o && !to_usb_ready_i && !rst_i) begin
            d = (resp_delay_force >= 0) ? resp_delay_force : int'($urandom_range(0, 3));
            repeat (d) @(negedge clk_i);
            to_usb_ready_i = 1'b1;
            @(negedge clk_i);
            to_usb_ready_i = 1'b0;
         end
      end
   end

   // Monitor
   initial begin
      strobe_t    s;
      logic [7:0] r;
      logic       prev_valid = 1'b0;
      logic       prev_hs    = 1'b0;
      logic [7:0] prev_data  = '0;
      forever begin
         @(negedge clk_i);
         #2;
         if (rst_i) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
         end else begin
            if (config_strobe_o) begin
               if (exp_strobe.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_strobe: got data 0x%0h, expected no strobe", config_data_o);
               end else begin
                  s = exp_strobe.pop_front();
                  check("strobe_data",  config_data_o,       s.data);
                  check("strobe_count", 32'(word_count_o),   32'(s.count));
               end
            end
            if (to_usb_valid_o) begin
               if (prev_valid && !prev_hs) check("resp_stable", 32'(to_usb_data_o), 32'(prev_data));
               if (from_usb_valid_i) check("ready_low_in_resp", 32'(from_usb_ready_o), 32'd0);
               if (to_usb_ready_i) begin
                  if (exp_resp.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_resp: got 0x%0h, expected no status byte", to_usb_data_o);
                  end else begin
                     r = exp_resp.pop_front();
                     check("resp_byte", 32'(to_usb_data_o), 32'(r));
                  end
               end
            end
            prev_valid = to_usb_valid_o;
            prev_data  = to_usb_data_o;
            prev_hs    = to_usb_valid_o && to_usb_ready_i;
         end
      end
   end

   initial begin
      int rr;
      int w;
      #1 rst_i = 1'b1;
      #2 check_reset_values();
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Basic session
      send_word(1, SYNC);
      check("active_after_sync", 32'(config_active_o), 32'd1);
      send_word(1, 32'h0102_0304);
      check("cdata_word1", config_data_o, 32'h0102_0304);
      check("count_word1", 32'(word_count_o), 32'd1);
      send_word(0, DESYNC);
      wait_resp_done();
      check("idle_after_ack", 32'(config_active_o), 32'd0);

      // Misaligned junk before sync, then a 3-word session
      send(0, 8'h00);
      send(0, 8'hFA);
      send_word(0, SYNC);
      send_word(0, 32'hAABB_CCDD);
      check("cdata_misaligned", config_data_o, 32'hAABB_CCDD);
      send_word(0, 32'h1234_5678);
      send_word(0, 32'hDEAD_BEEF);
      check("count_three", 32'(word_count_o), 32'd3);
      send_word(0, DESYNC);
      wait_resp_done();
      check("count_holds", 32'(word_count_o), 32'd3);
      check("ready_after_ack", 32'(from_usb_ready_o), 32'd1);

      // Host stalls the status byte while new bytes are offered
      send_word(0, SYNC);
      send_word(0, 32'h5555_AAAA);
      resp_delay_force = 50;
      send_word(0, DESYNC);
      send(0, 8'h42);
      resp_delay_force = -1;
      wait_resp_done();

      // Inactivity timeout with a partial word
      send_word(0, SYNC);
      send(0, 8'h11);
      send(0, 8'h22);
      silence(TMO + 50);
      wait_resp_done();
      check("active_after_nak", 32'(config_active_o), 32'd0);
      check("count_after_nak",  32'(word_count_o),    32'd0);

      // Byte landing on the final timeout cycle wins; one cycle later loses
      send_word(0, SYNC);
      send(TMO - 1, 8'h9A);
      send(0, 8'hBC);
      send(0, 8'hDE);
      send(0, 8'hF0);
      check("cdata_edge", config_data_o, 32'h9ABC_DEF0);
      send(TMO, 8'h77);
      wait_resp_done();

      // Reset between bytes 2 and 3 of a word
      send_word(0, SYNC);
      send_word(0, 32'hCAFE_F00D);
      send(0, 8'h01);
      send(0, 8'h02);
      rst_i = 1'b1;
      #1 check_reset_values();
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      send_word(0, 32'h1122_3344);
      check("no_session_after_rst", 32'(config_active_o), 32'd0);
      send_word(0, SYNC);
      send_word(0, 32'h0BAD_CAFE);
      check("count_after_resync", 32'(word_count_o), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rr = $urandom_range(0, 99);
         if (rr < 12)       send_word($urandom_range(0, 3), SYNC);
         else if (rr < 20)  send_word($urandom_range(0, 3), DESYNC);
         else if (rr < 30)  send($urandom_range(0, 3), 8'($urandom));
         else if (rr < 33)  silence(TMO + $urandom_range(0, 20));
         else if (rr < 37)  send(TMO - 1 + $urandom_range(0, 1), 8'($urandom));
         else               send_word($urandom_range(0, 3), 32'($urandom));
      end
      silence(TMO + 10);
      wait_resp_done();

      w = 0;
      while (exp_strobe.size() != 0 && w < 100) begin
         @(negedge clk_i);
         w++;
      end
      check("strobe_queue_empty", 32'(exp_strobe.size()), 32'd0);
      check("resp_queue_empty",   32'(exp_resp.size()),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/efpga_config_bridge.md
# efpga_config_bridge

Consumes the byte stream arriving on the eFPGA channel of the USB CDC core and converts it into 32-bit configuration words for the FABulous fabric configuration port. It hunts for a sync word, packs the following bytes MSB-first into words and strobes each word out. On a desync word or an inactivity timeout it returns a one-byte status to the host over the same channel's IN path. It sits between the CDC channel 0 (EFPGA) handshake signals and the fabric config interface, next to the JTAG bridge on channel 2.

## Interface
- SYNC_WORD, 32'hFAB0_FAB1, word that opens a configuration session
- DESYNC_WORD, 32'hFAB0_FAB0, word that closes a session; never forwarded
- TIMEOUT_CYCLES, 24'd12_000_000, idle clk_i cycles in ACTIVE before abort (1 s at 12 MHz); must be ≥ 2
- clk_i  in  1  system clock, same domain as the CDC application side
- rst_i  in  1  reset; asynchronous, active-high
- from_usb_data_i  in  8  OUT-endpoint byte
- from_usb_valid_i  in  1  byte valid
- from_usb_ready_o  out  1  bridge accepts byte
- to_usb_data_o  out  8  status byte to host
- to_usb_valid_o  out  1  status byte valid
- to_usb_ready_i  in  1  CDC IN path accepts status byte
- config_data_o  out  32  configuration word
- config_strobe_o  out  1  one-cycle pulse, config_data_o valid
- config_active_o  out  1  high while a session is open
- word_count_o  out  16  words forwarded in the current or last session

## Operation
- Byte accepted iff from_usb_valid_i && from_usb_ready_o.
- States: IDLE, ACTIVE, RESP.
- IDLE: ready = 1. Each accepted byte shifts into a 32-bit register, `sr <= {sr[23:0], byte}`. When the post-shift value equals SYNC_WORD:
  - go to ACTIVE;
  - clear the byte index (2 bits) and word_count_o;
  - clear the shift register.
- ACTIVE: ready = 1; config_active_o = 1.
  - Each accepted byte shifts in and increments the byte index.
  - On index 3, the completed word is either DESYNC_WORD or a data word.
  - DESYNC_WORD: load ACK 8'h06, go to RESP; no strobe.
  - Data word: register it on config_data_o, pulse config_strobe_o, increment word_count_o (wraps 0xFFFF→0).
- Timeout counter:
  - Cleared on entering ACTIVE and on every accepted byte; increments each cycle otherwise.
  - At TIMEOUT_CYCLES-1: discard the partial word, load NAK 8'h15, go to RESP.
  - If a byte is accepted in the same cycle, the byte wins and the counter clears.
- RESP: ready = 0; to_usb_valid_o = 1 with the loaded byte. When to_usb_ready_i = 1: drop valid, clear the shift register, go to IDLE.
- A SYNC_WORD received inside ACTIVE is treated as an ordinary data word.
- config_data_o holds its last value between strobes.

## Timing
- Reset values: from_usb_ready_o = 1 (IDLE), to_usb_valid_o = 0, to_usb_data_o = 0, config_data_o = 0, config_strobe_o = 0, config_active_o = 0, word_count_o = 0.
- Reset mid-session aborts the session silently; no NAK is sent.
- Strobe latency: config_strobe_o is high in the cycle after the 4th byte's handshake. Back-to-back bytes give at most one strobe per 4 cycles.
- config_active_o rises the cycle after the last sync byte is accepted, and falls the cycle after the 4th desync byte or after timeout.
- to_usb_valid_o rises one cycle after the desync handshake or timeout. It stays high until to_usb_ready_i, and to_usb_data_o is stable while valid.
- No combinational path from any input to any output; ready is a decode of registered state.

## Structure
- Package efpga_config_pkg holds:
  - state encoding (IDLE/ACTIVE/RESP);
  - ACK_BYTE = 8'h06, NAK_BYTE = 8'h15;
  - default SYNC_WORD, DESYNC_WORD and TIMEOUT_CYCLES constants.
- Sub-module efpga_word_packer owns the shift register, byte index and word-complete flag (clear input, byte/valid in, word + done out). It is reused for sync hunting and data packing.
- Timeout counter and FSM stay in the top module.

## Test plan
- Bytes FA B0 FA B1, then 01 02 03 04 -> config_active_o = 1; one strobe with config_data_o = 32'h01020304; word_count_o = 1.
- Junk 00 FA FA B0 FA B1 then AA BB CC DD -> sync found despite the misaligned prefix; strobe with 32'hAABBCCDD.
- Session with 3 data words, then FA B0 FA B0 -> 3 strobes, no strobe for the desync word; to_usb_data_o = 8'h06; ready = 0 until to_usb_ready_i, then IDLE.
- TIMEOUT_CYCLES = 100; sync, then 2 bytes, then silence -> to_usb_data_o = 8'h15 after 100 idle cycles; no strobe; config_active_o = 0.
- to_usb_ready_i held low 50 cycles in RESP with valid bytes offered -> no byte accepted, data and valid stable. Byte arriving in the exact timeout cycle -> counter clears, no NAK.
- rst_i asserted between bytes 2 and 3 of a word -> all outputs return to reset values immediately; next byte sequence must re-sync.
